shift_ser_tx: RTL and testbench

Parallel-to-serial transmitter that feeds the 4-bit bidirectional shift register (push/pop stack) from a parallel word source. It accepts a WIDTH-bit word over a valid/ready handshake and issues WIDTH push strobes (serial bit plus enable plus direction) so the word lands in the downstream register in order. On request it issues WIDTH pop strobes to empty the downstream register. It sits between the control/datapath logic and the shift register's `in`/`enb`/`dir` pins.

---
 rtl/shift_ser_tx.sv | 178 +++++++++++++++++
 tb/tb_shift_ser_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_ser_tx.sv
// shift_ser_tx
// Parallel-to-serial transmitter. It loads a 4-bit (by default) bidirectional
// shift register, used as a push/pop stack, one bit at a time.
// A word accepted over valid/ready is sent as WIDTH push strobes, LSB first.
// A drain request is sent as WIDTH pop strobes.
//
// Handshake: a word transfers on a rising edge where valid_i && ready_o.
// ready_o depends only on registered state, so the source may hold valid_i
// high for as long as it likes. data_in_i is sampled on that edge only.
//
// Optional feature: define SHIFT_SER_TX_SKID_EN to add a one-entry holding
// register. With it, the next word can be accepted while a word or drain is
// in flight, and back-to-back words go out with no idle gap.
//
// Parameters:
//   WIDTH  bits per word, equal to the downstream register depth (>= 2)
//   DIV    clock cycles per bit period (>= 1)
// Ports:
//   clk          clock, rising edge
//   rstn         synchronous active-low reset
//   data_in_i    word to transmit
//   valid_i      data_in_i valid
//   ready_o      block can accept a word this cycle
//   drain_req_i  level request to issue WIDTH pops
//   sout_o       serial bit to downstream `in`
//   senb_o       one-cycle shift strobe to downstream `enb`
//   sdir_o       1 = push, 0 = pop, to downstream `dir`
//   busy_o       state is not IDLE
//   done_o       pulse with the last strobe of a word or drain
//   state_o      current FSM state (debug)
module shift_ser_tx #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             drain_req_i,
    output logic             sout_o,
    output logic             senb_o,
    output logic             sdir_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       state_o
);

    localparam int BW = $clog2(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DLAST = DW'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bcnt_q,  bcnt_d;
    logic [DW-1:0]    dcnt_q,  dcnt_d;
    logic             strobe;
    logic             last;

`ifdef SHIFT_SER_TX_SKID_EN
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             accept;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bcnt_q      <= '0;
            dcnt_q      <= '0;
`ifdef SHIFT_SER_TX_SKID_EN
            hold_q      <= '0;
            hold_full_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bcnt_q      <= bcnt_d;
            dcnt_q      <= dcnt_d;
`ifdef SHIFT_SER_TX_SKID_EN
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
`endif
        end
    end

    // A strobe is due at the end of every bit period while a word or drain is active.
    assign strobe = (state_q != ST_IDLE) && (dcnt_q == DLAST);
    assign last   = strobe && (bcnt_q == BLAST);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        dcnt_d  = dcnt_q;
`ifdef SHIFT_SER_TX_SKID_EN
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        accept      = valid_i && !hold_full_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // A word wins over a drain request that arrives in the same cycle.
                if (valid_i) begin
                    shreg_d = data_in_i;
                    bcnt_d  = '0;
                    dcnt_d  = '0;
                    state_d = ST_SHIFT;
                end else if (drain_req_i) begin
                    bcnt_d  = '0;
                    dcnt_d  = '0;
                    state_d = ST_DRAIN;
                end
            end

            ST_SHIFT, ST_DRAIN: begin
                dcnt_d = strobe ? '0 : dcnt_q + DW'(1);
                if (strobe) begin
                    bcnt_d = bcnt_q + BW'(1);
                    if (state_q == ST_SHIFT) begin
                        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                    end
                end
                if (last) begin
                    bcnt_d  = '0;
                    dcnt_d  = '0;
                    state_d = ST_IDLE;
`ifdef SHIFT_SER_TX_SKID_EN
                    // Chain straight into the next word, with no idle cycle.
                    // A word that arrives on the done cycle itself bypasses the
                    // holding register.
                    if (hold_full_q) begin
                        shreg_d     = hold_q;
                        hold_full_d = 1'b0;
                        state_d     = ST_SHIFT;
                    end else if (accept) begin
                        shreg_d = data_in_i;
                        state_d = ST_SHIFT;
                    end
`endif
                end
`ifdef SHIFT_SER_TX_SKID_EN
                else if (accept) begin
                    hold_d      = data_in_i;
                    hold_full_d = 1'b1;
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All outputs are decoded from registered state only.
    assign senb_o  = strobe;
    assign done_o  = last;
    assign sout_o  = (state_q == ST_SHIFT) ? shreg_q[0] : 1'b0;
    assign sdir_o  = (state_q == ST_SHIFT);
    assign busy_o  = (state_q != ST_IDLE);
    assign state_o = state_q;
`ifdef SHIFT_SER_TX_SKID_EN
    assign ready_o = !hold_full_q;
`else
    assign ready_o = (state_q == ST_IDLE);
`endif

endmodule

// File: tb/tb_shift_ser_tx.sv
// tb_shift_ser_tx
// Self-checking bench for shift_ser_tx. It instantiates two copies:
// index 0 has DIV = 1 and index 1 has DIV = 3, both with WIDTH = 4.
// Expected outputs for each cycle of a word or drain come from the timing
// rules: a strobe at the end of each DIV-cycle bit period, bit j of the word
// during period j, and done on the final cycle.
// A behavioural model of the downstream push/pop register follows the strobes.
// At the end of a word it must hold the word; at the end of a drain it must
// hold zero.
module tb_shift_ser_tx;

    logic clk;
    logic rstn;

    logic [3:0] data_w  [2];
    logic       valid_w [2];
    logic       drain_w [2];
    logic       ready_w [2];
    logic       sout_w  [2];
    logic       senb_w  [2];
    logic       sdir_w  [2];
    logic       busy_w  [2];
    logic       done_w  [2];
    logic [1:0] state_w [2];

    logic [3:0] dsreg [2];

    int total = 0;
    int bad   = 0;

    shift_ser_tx #(.WIDTH(4), .DIV(1)) u_dut_d1 (
        .clk(clk), .rstn(rstn),
        .data_in_i(data_w[0]), .valid_i(valid_w[0]), .ready_o(ready_w[0]),
        .drain_req_i(drain_w[0]), .sout_o(sout_w[0]), .senb_o(senb_w[0]),
        .sdir_o(sdir_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]),
        .state_o(state_w[0])
    );

    shift_ser_tx #(.WIDTH(4), .DIV(3)) u_dut_d3 (
        .clk(clk), .rstn(rstn),
        .data_in_i(data_w[1]), .valid_i(valid_w[1]), .ready_o(ready_w[1]),
        .drain_req_i(drain_w[1]), .sout_o(sout_w[1]), .senb_o(senb_w[1]),
        .sdir_o(sdir_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]),
        .state_o(state_w[1])
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Downstream model: a push shifts in at out3 (so the first bit ends at out0),
    // and a pop shifts toward out3 and fills with zero.
    task automatic model_step(input int i);
        if (senb_w[i]) begin
            if (sdir_w[i]) dsreg[i] = {sout_w[i], dsreg[i][3:1]};
            else           dsreg[i] = {dsreg[i][2:0], 1'b0};
        end
    endtask

    task automatic check_idle(input int i, input string tag);
        check_eq({tag, "_ready"}, ready_w[i], 1);
        check_eq({tag, "_busy"},  busy_w[i],  0);
        check_eq({tag, "_senb"},  senb_w[i],  0);
        check_eq({tag, "_sout"},  sout_w[i],  0);
        check_eq({tag, "_sdir"},  sdir_w[i],  0);
        check_eq({tag, "_done"},  done_w[i],  0);
    endtask

    // Send one word from IDLE. The caller may also raise drain_req in the
    // acceptance cycle to check that the word has priority.
    task automatic send_word(input int i, input logic [3:0] d, input bit also_drain);
        int dv;
        int n;
        dv = div_of(i);
        n  = 4 * dv;
        check_eq("word_pre_ready", ready_w[i], 1);
        data_w[i]  = d;
        valid_w[i] = 1'b1;
        drain_w[i] = also_drain;
        @(posedge clk); #1;
        valid_w[i] = 1'b0;
        drain_w[i] = 1'b0;
        for (int t = 0; t < n; t++) begin
            data_w[i] = 4'($urandom);
            check_eq("word_senb", senb_w[i], ((t % dv) == dv - 1) ? 1 : 0);
            check_eq("word_sout", sout_w[i], d[t / dv]);
            check_eq("word_sdir", sdir_w[i], 1);
            check_eq("word_busy", busy_w[i], 1);
            check_eq("word_done", done_w[i], (t == n - 1) ? 1 : 0);
`ifndef SHIFT_SER_TX_SKID_EN
            check_eq("word_ready", ready_w[i], 0);
            // valid while busy must be ignored
            valid_w[i] = (t < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
`endif
            model_step(i);
            @(posedge clk); #1;
        end
        valid_w[i] = 1'b0;
        check_idle(i, "word_post");
        check_eq("word_reg", dsreg[i], d);
    endtask

    task automatic drain(input int i);
        int dv;
        int n;
        dv = div_of(i);
        n  = 4 * dv;
        drain_w[i] = 1'b1;
        @(posedge clk); #1;
        drain_w[i] = 1'b0;
        for (int t = 0; t < n; t++) begin
            check_eq("drain_senb", senb_w[i], ((t % dv) == dv - 1) ? 1 : 0);
            check_eq("drain_sout", sout_w[i], 0);
            check_eq("drain_sdir", sdir_w[i], 0);
            check_eq("drain_busy", busy_w[i], 1);
            check_eq("drain_done", done_w[i], (t == n - 1) ? 1 : 0);
            model_step(i);
            @(posedge clk); #1;
        end
        check_idle(i, "drain_post");
        check_eq("drain_reg", dsreg[i], 0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            data_w[i]  = '0;
            valid_w[i] = 1'b0;
            drain_w[i] = 1'b0;
            dsreg[i]   = '0;
        end
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle(0, "reset_d1");
        check_idle(1, "reset_d3");
        rstn = 1'b1;
        @(posedge clk); #1;

        // directed cases
        send_word(0, 4'b1011, 1'b0);
        send_word(1, 4'b0110, 1'b0);
        send_word(0, 4'b1111, 1'b0);
        drain(0);
        send_word(1, 4'b1111, 1'b0);
        drain(1);
        send_word(0, 4'b1100, 1'b1);
        send_word(1, 4'b0011, 1'b1);

        // reset after the second strobe of 4'b1001 (DIV = 1)
        data_w[0]  = 4'b1001;
        valid_w[0] = 1'b1;
        @(posedge clk); #1;
        valid_w[0] = 1'b0;
        check_eq("rst_s1_senb", senb_w[0], 1);
        check_eq("rst_s1_sout", sout_w[0], 1);
        model_step(0);
        @(posedge clk); #1;
        check_eq("rst_s2_senb", senb_w[0], 1);
        check_eq("rst_s2_sout", sout_w[0], 0);
        model_step(0);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        check_idle(0, "rst_mid");
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            check_eq("rst_quiet_senb", senb_w[0], 0);
            check_eq("rst_quiet_busy", busy_w[0], 0);
        end
        send_word(0, 4'b0101, 1'b0);

        // randomized traffic
        for (int k = 0; k < 10; k++) begin
            int i;
            i = int'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) drain(i);
            else send_word(i, 4'($urandom), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end

`ifdef SHIFT_SER_TX_SKID_EN
        // back-to-back words through the holding register (DIV = 1)
        begin
            logic [7:0] pair;
            pair = 8'h5A;
            data_w[0]  = 4'hA;
            valid_w[0] = 1'b1;
            @(posedge clk); #1;
            check_eq("skid_ready_c1", ready_w[0], 1);
            data_w[0] = 4'h5;
            for (int t = 0; t < 8; t++) begin
                if (t == 1) valid_w[0] = 1'b0;
                check_eq("skid_senb", senb_w[0], 1);
                check_eq("skid_sout", sout_w[0], pair[t]);
                check_eq("skid_done", done_w[0], (t == 3 || t == 7) ? 1 : 0);
                if (t >= 1) check_eq("skid_ready", ready_w[0], (t >= 4) ? 1 : 0);
                model_step(0);
                @(posedge clk); #1;
            end
            check_idle(0, "skid_post");
            check_eq("skid_reg", dsreg[0], 4'h5);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
